// File: rtl/reg_bank_arbiter_pkg.sv
// Shared types and defaults for the register bank sequencer.
package reg_bank_arbiter_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_NREGS  = 4;
  localparam int unsigned DEF_ADDR_W = $clog2(DEF_NREGS);

  // Writer identifiers, also used as grant vector bit positions
  localparam logic W1 = 1'b0;
  localparam logic W2 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR1  = 2'd1,
    ST_WR2  = 2'd2,
    ST_RD   = 2'd3
  } state_e;

endpackage

// File: rtl/reg_bank_arbiter_rr_arb2.sv
// Two-way round-robin arbiter for the writer pair (purely combinational).
module rr_arb2
  import reg_bank_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  input  logic       i_enable,
  output logic [1:0] o_grant_c,
  output logic       o_ptr_nxt_c
);

  // Grant the pointed writer on contention, the lone requester otherwise
  always_comb begin
    o_grant_c   = 2'b00;
    o_ptr_nxt_c = i_ptr;
    if (i_enable) begin
      if (&i_req) begin
        o_grant_c = (i_ptr == W2) ? 2'b10 : 2'b01;
      end else begin
        o_grant_c = i_req;
      end
      if (o_grant_c[W1]) begin
        o_ptr_nxt_c = W2;
      end else if (o_grant_c[W2]) begin
        o_ptr_nxt_c = W1;
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by two writers and one reader; one transaction per two cycles.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr1_req,
  input  logic [ADDR_W-1:0] wr1_addr,
  input  logic [DATA_W-1:0] wr1_data,
  output logic              wr1_ack,
  input  logic              wr2_req,
  input  logic [ADDR_W-1:0] wr2_addr,
  input  logic [DATA_W-1:0] wr2_data,
  output logic              wr2_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy
);

  state_e              r_state;
  state_e              w_state_nxt;
  logic                r_ptr;
  logic                r_last_rd;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic [DATA_W-1:0]   r_bank [NREGS];
  logic                r_wr1_ack;
  logic                r_wr2_ack;
  logic                r_rd_valid;
  logic                r_busy;
  logic [DATA_W-1:0]   r_rd_data;

  logic [1:0]          w_wr_req;
  logic [1:0]          w_wr_grant;
  logic                w_ptr_nxt;
  logic                w_rd_win;
  logic                w_arb_en;

  assign w_wr_req = {wr2_req, wr1_req};

  // Read wins unless the previous grant was a read and a writer is waiting
  assign w_rd_win = rd_req & ~(r_last_rd & (|w_wr_req));
  assign w_arb_en = (r_state == ST_IDLE) & ~w_rd_win;

  rr_arb2 u_wr_arb (
    .i_req       (w_wr_req),
    .i_ptr       (r_ptr),
    .i_enable    (w_arb_en),
    .o_grant_c   (w_wr_grant),
    .o_ptr_nxt_c (w_ptr_nxt)
  );

  // Next-state: grant from IDLE, every transaction state lasts one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_win) begin
          w_state_nxt = ST_RD;
        end else if (w_wr_grant[W1]) begin
          w_state_nxt = ST_WR1;
        end else if (w_wr_grant[W2]) begin
          w_state_nxt = ST_WR2;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Moore outputs registered alongside the state they decode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr1_ack  <= 1'b0;
      r_wr2_ack  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_wr1_ack  <= (w_state_nxt == ST_WR1);
      r_wr2_ack  <= (w_state_nxt == ST_WR2);
      r_rd_valid <= (w_state_nxt == ST_RD);
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

  // Grant bookkeeping: latch winner payload, move pointers, capture read data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr     <= W1;
      r_last_rd <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_rd_data <= '0;
    end else if (r_state == ST_IDLE) begin
      case (w_state_nxt)
        ST_RD: begin
          r_last_rd <= 1'b1;
          r_rd_data <= r_bank[rd_addr];
        end
        ST_WR1: begin
          r_addr    <= wr1_addr;
          r_data    <= wr1_data;
          r_last_rd <= 1'b0;
          r_ptr     <= w_ptr_nxt;
        end
        ST_WR2: begin
          r_addr    <= wr2_addr;
          r_data    <= wr2_data;
          r_last_rd <= 1'b0;
          r_ptr     <= w_ptr_nxt;
        end
        default: ;
      endcase
    end
  end

  // Bank storage: commit on the exit edge of a write state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        r_bank[i] <= '0;
      end
    end else if ((r_state == ST_WR1) || (r_state == ST_WR2)) begin
      r_bank[r_addr] <= r_data;
    end
  end

  assign wr1_ack  = r_wr1_ack;
  assign wr2_ack  = r_wr2_ack;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign busy     = r_busy;

endmodule
